// File: rtl/booth_div.sv
// booth_div: 8-bit by 4-bit signed divider (truncating division).
// One unsigned restoring step per clock. Signs are applied once, in the FIX state.
// Optional feature: define DIV_ZERO_DETECT_EN to add the div_zero port.
// With that feature, a zero divisor bypasses the iterations.
// DV_PULSE selects a one-cycle div_dv (1) or a div_dv held until the next load (0).
module booth_div #(
  parameter int DV_PULSE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic signed [7:0] Dividend,
  input  logic signed [3:0] Divisor,
  output logic signed [7:0] Quotient,
  output logic signed [3:0] Remainder,
  output logic              div_dv,
  output logic              busy
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic              div_zero
`endif
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 4;
  localparam int STAGES = DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   dvd_sh;    // dividend magnitude, consumed MSB first
  logic [COEF_W-1:0]   dvs_mag;
  logic [COEF_W:0]     rem;       // partial remainder, one guard bit
  logic [DATA_W-1:0]   quo;
  logic [3:0]          cnt;
  logic                neg_q;
  logic                neg_r;
  logic [COEF_W:0]     rem_sh;
  logic [COEF_W+1:0]   diff;
  logic                step_ok;
`ifdef DIV_ZERO_DETECT_EN
  logic                dz_pend;
`endif

  // Two's-complement negation helpers; -128 maps onto itself (wrap modulo 2^8).
  function automatic logic [DATA_W-1:0] neg_d(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [COEF_W-1:0] neg_c(input logic [COEF_W-1:0] v);
    return ~v + {{(COEF_W-1){1'b0}}, 1'b1};
  endfunction

  // Restoring step: shift in next dividend bit, trial-subtract the divisor magnitude.
  always_comb begin
    rem_sh  = {rem[COEF_W-1:0], dvd_sh[DATA_W-1]};
    diff    = {1'b0, rem_sh} - {2'b00, dvs_mag};
    step_ok = ~diff[COEF_W+1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a load overrides whatever the FSM was doing.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cnt == 4'd1) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = state;
    endcase
    if (load) begin
      state_nxt = RUN;
`ifdef DIV_ZERO_DETECT_EN
      if (Divisor == '0) state_nxt = FIX;
`endif
    end
  end

  // Operand capture, iteration datapath and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh    <= '0;
      dvs_mag   <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      div_dv    <= 1'b0;
      busy      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_pend   <= 1'b0;
      div_zero  <= 1'b0;
`endif
    end else if (load) begin
      dvd_sh    <= Dividend[DATA_W-1] ? neg_d(Dividend) : Dividend;
      dvs_mag   <= Divisor[COEF_W-1] ? neg_c(Divisor) : Divisor;
      neg_q     <= Dividend[DATA_W-1] ^ Divisor[COEF_W-1];
      neg_r     <= Dividend[DATA_W-1];
      rem       <= '0;
      quo       <= '0;
      cnt       <= 4'(STAGES);
      Quotient  <= '0;
      Remainder <= '0;
      div_dv    <= 1'b0;
      busy      <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
      dz_pend   <= (Divisor == '0);
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          rem    <= step_ok ? diff[COEF_W:0] : rem_sh;
          quo    <= {quo[DATA_W-2:0], step_ok};
          dvd_sh <= {dvd_sh[DATA_W-2:0], 1'b0};
          cnt    <= cnt - 4'd1;
        end
        FIX: begin
          Quotient  <= neg_q ? neg_d(quo) : quo;
          Remainder <= neg_r ? neg_c(rem[COEF_W-1:0]) : rem[COEF_W-1:0];
          div_dv    <= 1'b1;
          busy      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
          if (dz_pend) begin
            Quotient  <= '0;
            Remainder <= '0;
            div_zero  <= 1'b1;
          end
`endif
        end
        default: begin
          if (DV_PULSE != 0) div_dv <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div.sv
// Directed bench for booth_div: one instance per DV_PULSE setting, shared inputs.
module tb_booth_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] dvd = '0;
  logic [3:0] dvs = '0;
  logic [7:0] q0, q1;
  logic [3:0] r0, r1;
  logic       dv0, dv1, busy0, busy1;
`ifdef DIV_ZERO_DETECT_EN
  logic       dz0, dz1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_div #(.DV_PULSE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .Dividend(dvd), .Divisor(dvs),
    .Quotient(q0), .Remainder(r0), .div_dv(dv0), .busy(busy0)
`ifdef DIV_ZERO_DETECT_EN
    , .div_zero(dz0)
`endif
  );

  booth_div #(.DV_PULSE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .Dividend(dvd), .Divisor(dvs),
    .Quotient(q1), .Remainder(r1), .div_dv(dv1), .busy(busy1)
`ifdef DIV_ZERO_DETECT_EN
    , .div_zero(dz1)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic start_div(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    load = 1'b1;
    dvd  = a;
    dvs  = b;
  endtask

  // Load edge already armed by the caller; checks clearing, latency and result.
  task automatic finish_div(input string tag, input logic [7:0] eq, input logic [3:0] er,
                            input bit chk_val);
    int lat;
    bit early_dv;
    @(posedge clk); #1;
    check({tag, " load busy"}, int'(busy0), 1);
    check({tag, " load dv"}, int'(dv0), 0);
    check({tag, " load q clr"}, int'(q0), 0);
    @(negedge clk);
    load = 1'b0;
    lat = 0;
    early_dv = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (!busy0) begin
        lat = k;
        break;
      end
      if (dv0 || dv1) early_dv = 1'b1;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " early dv"}, int'(early_dv), 0);
    if (chk_val) begin
      check({tag, " q"}, int'(q0), int'(eq));
      check({tag, " r"}, int'(r0), int'(er));
      check({tag, " q pulse"}, int'(q1), int'(eq));
      check({tag, " r pulse"}, int'(r1), int'(er));
`ifdef DIV_ZERO_DETECT_EN
      check({tag, " dz"}, int'(dz0), 0);
`endif
    end
    check({tag, " dv"}, int'(dv0), 1);
    check({tag, " dv pulse"}, int'(dv1), 1);
    check({tag, " busy pulse"}, int'(busy1), 0);
    @(posedge clk); #1;
    check({tag, " dv hold"}, int'(dv0), 1);
    check({tag, " dv pulse clr"}, int'(dv1), 0);
    if (chk_val) check({tag, " q hold"}, int'(q0), int'(eq));
  endtask

  initial begin
    vecs[0]  = '{8'h64, 4'h7, 8'h0E, 4'h2};  // 100 / 7
    vecs[1]  = '{8'h9C, 4'h7, 8'hF2, 4'hE};  // -100 / 7
    vecs[2]  = '{8'h64, 4'h8, 8'hF4, 4'h4};  // 100 / -8
    vecs[3]  = '{8'h80, 4'hF, 8'h80, 4'h0};  // -128 / -1 wraps
    vecs[4]  = '{8'h80, 4'h7, 8'hEE, 4'hE};  // -128 / 7
    vecs[5]  = '{8'h7F, 4'h8, 8'hF1, 4'h7};  // 127 / -8
    vecs[6]  = '{8'hFF, 4'h3, 8'h00, 4'hF};  // -1 / 3
    vecs[7]  = '{8'h00, 4'h5, 8'h00, 4'h0};  // 0 / 5
    vecs[8]  = '{8'h80, 4'h8, 8'h10, 4'h0};  // -128 / -8
    vecs[9]  = '{8'h37, 4'h5, 8'h0B, 4'h0};  // 55 / 5
    vecs[10] = '{8'h14, 4'h3, 8'h06, 4'h2};  // 20 / 3
    vecs[11] = '{8'h7F, 4'h1, 8'h7F, 4'h0};  // 127 / 1
    vecs[12] = '{8'hF9, 4'h8, 8'h00, 4'h9};  // -7 / -8

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst q", int'(q0), 0);
    check("rst r", int'(r0), 0);
    check("rst dv", int'(dv0), 0);
    check("rst busy", int'(busy0), 0);
    check("rst dv pulse", int'(dv1), 0);

    // Load on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b1;
    dvd   = 8'h64;
    dvs   = 4'h7;
    finish_div("first", 8'h0E, 4'h2, 1'b1);

    foreach (vecs[i]) begin
      start_div(vecs[i].a, vecs[i].b);
      finish_div($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, 1'b1);
    end

    // Asynchronous reset in the middle of a division
    start_div(8'h64, 4'h7);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async busy", int'(busy0), 0);
    check("async q", int'(q0), 0);
    check("async dv", int'(dv0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post rst busy", int'(busy0), 0);
    check("post rst dv", int'(dv0), 0);
    check("post rst q", int'(q0), 0);
    check("post rst r", int'(r0), 0);

    // Reload at edge 5 aborts the first division
    start_div(8'h64, 4'h7);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(posedge clk);
    start_div(8'h14, 4'h3);
    finish_div("abort", 8'h06, 4'h2, 1'b1);

    // Load held high keeps recapturing
    start_div(8'h64, 4'h7);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold busy", int'(busy0), 1);
      check("hold dv", int'(dv0), 0);
      @(negedge clk);
      dvd = dvd - 8'd1;
    end
    dvd = 8'h37;
    dvs = 4'h5;
    finish_div("hold", 8'h0B, 4'h0, 1'b1);

    // Divide by zero
`ifdef DIV_ZERO_DETECT_EN
    start_div(8'h37, 4'h0);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk); #1;
    check("dz flag", int'(dz0), 1);
    check("dz dv", int'(dv0), 1);
    check("dz busy", int'(busy0), 0);
    check("dz q", int'(q0), 0);
    check("dz r", int'(r0), 0);
    start_div(8'h37, 4'h5);
    finish_div("after dz", 8'h0B, 4'h0, 1'b1);
`else
    start_div(8'h37, 4'h0);
    finish_div("zero div", 8'h00, 4'h0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_div.md
BOOTH_DIV -- requirements
Module: booth_div

Interface
REQ-001 SHALL provide parameter: DV_PULSE, 0, 0 = div_dv holds high until next load or reset; 1 = div_dv high for exactly one cycle.
REQ-002 SHALL provide port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: load  input  1  start; sampled at rising clk.
REQ-005 SHALL provide port: Dividend  input  8  signed two's-complement dividend.
REQ-006 SHALL provide port: Divisor  input  4  signed two's-complement divisor.
REQ-007 SHALL provide port: Quotient  output  8  signed quotient, registered.
REQ-008 SHALL provide port: Remainder  output  4  signed remainder, registered.
REQ-009 SHALL provide port: div_dv  output  1  result valid.
REQ-010 SHALL provide port: busy  output  1  high while a division is in progress.
REQ-011 SHALL provide port: div_zero  output  1  divide-by-zero flag; present only with DIV_ZERO_DETECT_EN.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; IDLE is the reset state.
REQ-013 On a rising edge with load=1, in any state, SHALL:
- capture |Dividend| (8b unsigned), |Divisor| (4b unsigned) and both sign bits;
- clear Quotient, Remainder, div_dv and div_zero;
- set iteration count to 8, set busy=1, enter RUN.
REQ-014 Load during RUN or FIX SHALL abort the current division with no div_dv and restart on the new operands.
REQ-015 In RUN, with load=0, SHALL perform one unsigned restoring step per cycle:
- shift the 5b partial remainder left, taking the next dividend MSB;
- subtract the divisor magnitude; if the result is non-negative, keep it and set quotient bit 1, else restore and set bit 0.
REQ-016 After the 8th step SHALL enter FIX; the operand-capture edge is edge 0, steps occur on edges 1-8, and FIX completes on edge 9.
REQ-017 On the FIX edge SHALL:
- write Quotient = magnitude quotient, negated if the operand signs differ;
- write Remainder = remainder magnitude, negated if Dividend is negative (truncating division);
- set div_dv=1 and busy=0, and return to IDLE.
REQ-018 Quotient SHALL wrap modulo 2^8: -128 / -1 gives Quotient 8'h80, Remainder 4'h0, with no flag.
REQ-019 Remainder magnitude SHALL always be less than the divisor magnitude (at most 7) and fit the 4b signed range.
REQ-020 With DV_PULSE=1, div_dv SHALL clear on the edge after FIX; with DV_PULSE=0 it SHALL hold until the next load or reset.
REQ-021 Quotient and Remainder SHALL hold their values in IDLE until the next load or reset.
REQ-022 Load held high SHALL recapture operands every cycle; div_dv SHALL stay 0 and busy SHALL stay 1.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk:
- set state IDLE;
- clear Quotient, Remainder, div_dv, busy, div_zero and all internal registers.
REQ-024 Reset asserted mid-RUN SHALL discard the division; after release, outputs SHALL stay zero until a new load completes.
REQ-025 A load sampled on the first rising edge after rst_n deasserts SHALL be honoured.

Configuration
REQ-026 Macro DIV_ZERO_DETECT_EN defined: the div_zero port exists. A load with Divisor=0 SHALL go directly to FIX, and on edge 1 SHALL produce Quotient=8'h00, Remainder=4'h0, div_zero=1, div_dv=1, busy=0.
REQ-027 Macro DIV_ZERO_DETECT_EN undefined: the div_zero port and its logic are absent. Divisor=0 SHALL still complete on edge 9 with div_dv=1, and Quotient/Remainder values are unspecified.

Verification
REQ-028 Dividend=100, Divisor=7, load one cycle -> busy for 9 edges; at edge 9 Quotient=8'h0E, Remainder=4'h2, div_dv=1.
REQ-029 Dividend=-100, Divisor=7 -> Quotient=8'hF2, Remainder=4'hE; then Dividend=100, Divisor=-8 -> Quotient=8'hF4, Remainder=4'h4.
REQ-030 Dividend=-128, Divisor=-1 -> Quotient=8'h80, Remainder=4'h0, div_dv=1 at edge 9.
REQ-031 With the macro defined: Dividend=55, Divisor=0 -> at edge 1 div_zero=1, div_dv=1, Quotient=8'h00; a following 55/5 load -> div_zero=0, Quotient=8'h0B, Remainder=4'h0.
REQ-032 Start 100/7, assert rst_n=0 at edge 4 -> all outputs 0 asynchronously; start 100/7, reload 20/3 at edge 5 -> no div_dv for the first operation; Quotient=8'h06, Remainder=4'h2 nine edges after the reload.
REQ-033 With DV_PULSE=1: 100/7 -> div_dv high exactly one cycle; with DV_PULSE=0 -> div_dv stays high until the next load.
